// File: rtl/hci_mem_pipe_stage_pkg.sv
// Shared width defaults for the HCI memory pipe stage.
package hci_mem_pipe_stage_pkg;

  localparam int unsigned DefaultDw = 32;
  localparam int unsigned DefaultAw = 32;
  localparam int unsigned DefaultBw = 8;
  localparam int unsigned DefaultIw = 10;
  localparam int unsigned DefaultUw = 1;

endpackage

// File: rtl/hci_mem_req_fifo2.sv
// Two-entry request FIFO; outputs come only from registers, never from data_i.
module hci_mem_req_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [1:0]       count_q, count_d;
  logic             wptr_q, wptr_d;
  logic             rptr_q, rptr_d;
  logic [Width-1:0] mem_q [2];
  logic [Width-1:0] mem_d [2];

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    if (clear_i) begin
      // Storage is left alone; only occupancy and pointers are flushed.
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push_i) begin
        mem_d[wptr_q] = data_i;
        wptr_d        = ~wptr_q;
      end
      if (pop_i) begin
        rptr_d = ~rptr_q;
      end
      if (push_i && !pop_i) begin
        count_d = count_q + 2'd1;
      end else if (pop_i && !push_i) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= 2'd0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      mem_q   <= mem_d;
    end
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/hci_mem_pipe_stage.sv
// Registered cut between the memory mux and a bank: buffers requests two deep and
// delays responses by one cycle. Ports are flat; in_* faces the mux, out_* the bank.
module hci_mem_pipe_stage
  import hci_mem_pipe_stage_pkg::*;
#(
  parameter int unsigned DW = DefaultDw,
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned BW = DefaultBw,
  parameter int unsigned IW = 10,
  parameter int unsigned UW = DefaultUw
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  // upstream (from mux)
  input  logic             in_req_i,
  output logic             in_gnt_o,
  input  logic [AW-1:0]    in_add_i,
  input  logic             in_wen_i,
  input  logic [DW-1:0]    in_data_i,
  input  logic [DW/BW-1:0] in_be_i,
  input  logic [IW-1:0]    in_id_i,
  input  logic [UW-1:0]    in_user_i,
  output logic             in_r_valid_o,
  output logic [DW-1:0]    in_r_data_o,
  output logic [IW-1:0]    in_r_id_o,
  output logic [UW-1:0]    in_r_user_o,
  // downstream (to bank)
  output logic             out_req_o,
  input  logic             out_gnt_i,
  output logic [AW-1:0]    out_add_o,
  output logic             out_wen_o,
  output logic [DW-1:0]    out_data_o,
  output logic [DW/BW-1:0] out_be_o,
  output logic [IW-1:0]    out_id_o,
  output logic [UW-1:0]    out_user_o,
  input  logic             out_r_valid_i,
  input  logic [DW-1:0]    out_r_data_i,
  input  logic [IW-1:0]    out_r_id_i,
  input  logic [UW-1:0]    out_r_user_i,
  output logic             busy_o
);

  typedef struct packed {
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW-1:0]    data;
    logic [DW/BW-1:0] be;
    logic [IW-1:0]    id;
    logic [UW-1:0]    user;
  } req_t;

  req_t push_data, head;
  logic full, empty, push, pop;

  // Grant depends only on registered occupancy, which is what cuts the gnt path.
  assign in_gnt_o  = !full && !clear_i;
  assign out_req_o = !empty;
  assign push      = in_req_i && in_gnt_o;
  assign pop       = out_req_o && out_gnt_i;

  assign push_data = '{add: in_add_i, wen: in_wen_i, data: in_data_i, be: in_be_i,
                       id: in_id_i, user: in_user_i};

  hci_mem_req_fifo2 #(
    .Width($bits(req_t))
  ) u_req_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear_i(clear_i),
    .push_i (push),
    .pop_i  (pop),
    .data_i (push_data),
    .data_o (head),
    .full_o (full),
    .empty_o(empty)
  );

  assign out_add_o  = head.add;
  assign out_wen_o  = head.wen;
  assign out_data_o = head.data;
  assign out_be_o   = head.be;
  assign out_id_o   = head.id;
  assign out_user_o = head.user;

  logic          r_valid_q, r_valid_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic [IW-1:0] r_id_q, r_id_d;
  logic [UW-1:0] r_user_q, r_user_d;

  always_comb begin
    r_valid_d = out_r_valid_i && !clear_i;
    r_data_d  = out_r_data_i;
    r_id_d    = out_r_id_i;
    r_user_d  = out_r_user_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
      r_user_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_id_q    <= r_id_d;
      r_user_q  <= r_user_d;
    end
  end

  assign in_r_valid_o = r_valid_q;
  assign in_r_data_o  = r_data_q;
  assign in_r_id_o    = r_id_q;
  assign in_r_user_o  = r_user_q;

  assign busy_o = !empty || r_valid_q;

endmodule

// File: tb/tb_hci_mem_pipe_stage.sv
// Directed bench for hci_mem_pipe_stage with a simple bank model answering reads.
module tb_hci_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        in_req, in_gnt, in_wen;
  logic [31:0] in_add, in_data;
  logic [3:0]  in_be;
  logic [9:0]  in_id;
  logic [0:0]  in_user;
  logic        in_r_valid;
  logic [31:0] in_r_data;
  logic [9:0]  in_r_id;
  logic [0:0]  in_r_user;
  logic        out_req, out_gnt, out_wen;
  logic [31:0] out_add, out_data;
  logic [3:0]  out_be;
  logic [9:0]  out_id;
  logic [0:0]  out_user;
  logic        busy;

  logic        bank_rv = 1'b0;
  logic [31:0] bank_rdata = '0;
  logic [9:0]  bank_rid = '0;
  logic        inj_rv = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] sb_q[$];
  logic [9:0] exp_id;

  always #5 clk = ~clk;

  hci_mem_pipe_stage dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .in_req_i     (in_req),
    .in_gnt_o     (in_gnt),
    .in_add_i     (in_add),
    .in_wen_i     (in_wen),
    .in_data_i    (in_data),
    .in_be_i      (in_be),
    .in_id_i      (in_id),
    .in_user_i    (in_user),
    .in_r_valid_o (in_r_valid),
    .in_r_data_o  (in_r_data),
    .in_r_id_o    (in_r_id),
    .in_r_user_o  (in_r_user),
    .out_req_o    (out_req),
    .out_gnt_i    (out_gnt),
    .out_add_o    (out_add),
    .out_wen_o    (out_wen),
    .out_data_o   (out_data),
    .out_be_o     (out_be),
    .out_id_o     (out_id),
    .out_user_o   (out_user),
    .out_r_valid_i(bank_rv),
    .out_r_data_i (bank_rdata),
    .out_r_id_i   (bank_rid),
    .out_r_user_i (1'b0),
    .busy_o       (busy)
  );

  // Bank: answers granted reads one cycle later; inj_rv forces a stray response.
  always @(posedge clk) begin
    bank_rv    <= (out_req && out_gnt && out_wen) || inj_rv;
    bank_rid   <= out_id;
    bank_rdata <= out_add ^ 32'hA5A5_0000;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; in_req = 1'b0; in_wen = 1'b0; in_add = '0;
    in_data = '0; in_be = 4'hF; in_id = '0; in_user = '0; out_gnt = 1'b0;
    #3;
    check("rst_out_req", out_req, 0);
    check("rst_in_gnt", in_gnt, 1);
    check("rst_busy", busy, 0);
    check("rst_r_valid", in_r_valid, 0);
    check("rst_r_data", in_r_data, 0);
    #9 rst_ni = 1'b1;
    step();

    // Single write
    in_req = 1'b1; in_add = 32'h40; in_data = 32'hDEAD_BEEF; in_wen = 1'b0; in_id = 10'd5;
    out_gnt = 1'b1;
    #1 check("wr_in_gnt", in_gnt, 1);
    step();
    in_req = 1'b0;
    #1;
    check("wr_out_req", out_req, 1);
    check("wr_out_add", out_add, 32'h40);
    check("wr_out_data", out_data, 32'hDEAD_BEEF);
    check("wr_out_id", out_id, 5);
    check("wr_busy1", busy, 1);
    step();
    check("wr_out_req_c2", out_req, 0);
    check("wr_busy_c2", busy, 0);

    // Streaming: 16 reads; response for read k shows up after edge k+2
    for (int j = 0; j < 18; j++) begin
      in_req = (j < 16); in_wen = 1'b1; in_add = 32'(4 * j); in_id = 10'(16 + j);
      #1;
      if (j < 16) check("st_in_gnt", in_gnt, 1);
      step();
      check("st_out_req", out_req, (j < 16) ? 1 : 0);
      check("st_r_valid", in_r_valid, (j >= 2) ? 1 : 0);
      if (j >= 2) begin
        check("st_r_id", in_r_id, 64'(16 + j - 2));
        check("st_r_data", in_r_data, 64'((32'(4 * (j - 2))) ^ 32'hA5A5_0000));
      end
    end
    step();
    check("st_busy_end", busy, 0);

    // Backpressure: ids 1,2,3 with out_gnt low for 4 cycles
    out_gnt = 1'b0; in_req = 1'b1; in_wen = 1'b0; in_id = 10'd1;
    #1 check("bp_gnt_c0", in_gnt, 1);
    step();
    in_id = 10'd2;
    #1;
    check("bp_gnt_c1", in_gnt, 1);
    check("bp_head_c1", out_id, 1);
    step();
    in_id = 10'd3;
    #1;
    check("bp_gnt_c2", in_gnt, 0);
    check("bp_head_c2", out_id, 1);
    step();
    check("bp_gnt_c3", in_gnt, 0);
    check("bp_head_c3", out_id, 1);
    out_gnt = 1'b1;
    step();
    check("bp_gnt_after_pop", in_gnt, 1);
    check("bp_order2", out_id, 2);
    step();
    in_req = 1'b0;
    #1;
    check("bp_order3", out_id, 3);
    check("bp_req3", out_req, 1);
    step();
    check("bp_empty", out_req, 0);

    // Simultaneous push/pop at count 1, with a scoreboard
    for (int j = 0; j < 5; j++) begin
      in_req = (j < 3); in_wen = 1'b0; in_id = 10'(40 + j); out_gnt = 1'b1;
      #1;
      check("sb_in_gnt", in_gnt, 1);
      if (j == 1 || j == 2) check("sb_count1_req", out_req, 1);
      if (out_req && out_gnt) begin
        exp_id = (sb_q.size() > 0) ? sb_q.pop_front() : 10'h3FF;
        check("sb_order", out_id, exp_id);
      end
      if (in_req && in_gnt) sb_q.push_back(in_id);
      step();
    end
    check("sb_drained", sb_q.size(), 0);
    check("sb_out_req", out_req, 0);

    // clear_i with count 2 and a response in flight
    out_gnt = 1'b0; in_req = 1'b1; in_wen = 1'b1; in_id = 10'd7;
    step();
    in_id = 10'd8; inj_rv = 1'b1;
    step();
    in_req = 1'b0;
    step();
    check("clr_pre_rvalid", in_r_valid, 1);
    check("clr_pre_gnt", in_gnt, 0);
    check("clr_pre_busy", busy, 1);
    inj_rv = 1'b0; clear_i = 1'b1; in_req = 1'b1; in_id = 10'd9;
    #1 check("clr_gnt_forced", in_gnt, 0);
    step();
    clear_i = 1'b0; in_req = 1'b0;
    #1;
    check("clr_out_req", out_req, 0);
    check("clr_r_valid", in_r_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_in_gnt", in_gnt, 1);
    step();
    check("clr_no_stray_rv", in_r_valid, 0);

    // Async reset mid-burst
    out_gnt = 1'b0; in_req = 1'b1; in_wen = 1'b1; in_id = 10'd11; in_add = 32'h80;
    step();
    in_req = 1'b0;
    #1 check("ar_pre_req", out_req, 1);
    #1 rst_ni = 1'b0;
    #1;
    check("ar_out_req", out_req, 0);
    check("ar_in_gnt", in_gnt, 1);
    check("ar_busy", busy, 0);
    check("ar_out_id", out_id, 0);
    #1 rst_ni = 1'b1;
    step();
    in_req = 1'b1; in_wen = 1'b0; in_add = 32'hC0; in_id = 10'd12; out_gnt = 1'b1;
    step();
    in_req = 1'b0;
    #1;
    check("ar_resume_req", out_req, 1);
    check("ar_resume_add", out_add, 32'hC0);
    step();
    check("ar_resume_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hci_mem_pipe_stage.md
# hci_mem_pipe_stage

Registered cut stage placed directly downstream of the static/dynamic memory mux, between the mux `out` port and the memory-side bank interface. It breaks the combinational `gnt` path with a 2-entry request buffer. It also breaks the `r_*` path with a one-cycle response register. Full request throughput (1 transfer/cycle) and request ordering are preserved.

## Interface
- DW, hci_package::DEFAULT_DW, data width
- AW, hci_package::DEFAULT_AW, address width
- BW, hci_package::DEFAULT_BW, byte width (be is DW/BW bits)
- WW, hci_package::DEFAULT_WW, word width (passed to interfaces only)
- IW, 10, request/response ID width
- UW, hci_package::DEFAULT_UW, user width
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush, active-high
- in  hci_mem_intf.slave  —  upstream request/response port (from mux)
- out  hci_mem_intf.master  —  downstream port (to memory bank)
- busy_o  out  1  high when buffer non-empty or response register valid

## Operation
- Request payload per entry: add, wen, data, be, id, user.
- Request buffer: 2 entries, write/read pointers (1 bit each), count 0..2.
- Push: `in.req && in.gnt`. `in.gnt = (count != 2) && !clear_i`. This is derived from registered count only, with no combinational dependency on `out.gnt`.
- Pop: `out.req && out.gnt`. `out.req = (count != 0)`. `out.add/wen/data/be/id/user` = head entry. The head is stable while `out.req` is high and not granted.
- Count update: push only +1; pop only −1; push and pop together, no change. Pointers wrap modulo 2.
- Ordering: strict FIFO; requests are never reordered or dropped.
- Response register: captures `out.r_valid`, `out.r_data`, `out.r_id`, `out.r_user` every cycle.
  - Drives `in.r_valid/r_data/r_id/r_user` from the register.
  - No backpressure on responses; every `out.r_valid` pulse appears exactly once on `in.r_valid`.
- clear_i: next edge sets count=0, pointers=0, response valid=0. Data/payload registers are not cleared. In-flight downstream responses arriving during the clear cycle are discarded.
- busy_o = (count != 0) || in.r_valid.

## Timing
- Reset (rst_ni low, async): count=0, pointers=0, in.r_valid=0, in.r_data/r_id/r_user=0. Hence out.req=0, in.gnt=1, busy_o=0. Payload storage is reset to 0.
- Request latency:
  - A request accepted at edge N appears on `out.req` in cycle N+1 at the earliest.
  - With out.gnt held at 1, count stays at 1 and throughput is 1/cycle.
- Backpressure:
  - With out.gnt=0, two requests are accepted, then in.gnt drops to 0 in the cycle count becomes 2.
  - in.gnt rises the cycle after the first pop.
- Response latency: +1 cycle versus the memory. A read granted downstream at edge M with bank r_valid at M+1 yields in.r_valid at M+2.
- Push when count=2 is impossible (gnt=0). Pop when count=0 is impossible (req=0).
- Reset mid-operation: buffered requests and pending responses are lost. Upstream must not rely on them.
- clear_i and push in the same cycle: no push (gnt forced 0). clear_i has priority over pop.

## Structure
- No new package types. Widths come from hci_package defaults. Request entry is a local packed struct `{add, wen, data, be, id, user}`.
- One natural sub-module: `hci_mem_req_fifo2`. It is a 2-entry flow-through-free FIFO with push/pop/full/empty/clear, parameterised on payload width. The response register stays inline.

## Test plan
- Single write: in.req=1, add=0x40, data=0xDEADBEEF, wen=0, out.gnt=1. Required: in.gnt=1 at edge 0; out.req=1 with add=0x40 in cycle 1; busy_o=0 by cycle 2.
- Streaming: 16 back-to-back reads, add=0x0..0x3C, out.gnt=1, bank r_valid one cycle after gnt with r_id=id. Required: 16 grants in 16 cycles; in.r_valid for id k exactly 3 cycles after its upstream grant, in order.
- Backpressure: out.gnt=0 for 4 cycles while in.req=1 with ids 1,2,3. Required:
  - ids 1,2 accepted; in.gnt=0 from cycle 2.
  - id 1 held stable on out.
  - After out.gnt=1, output order is 1,2,3.
- Simultaneous push/pop at count=1. Required: count stays 1; no gnt glitch; no duplicate or lost request (scoreboard match).
- clear_i mid-burst: with count=2 and a pending r_valid, pulse clear_i one cycle. Required: next cycle out.req=0, in.r_valid=0, busy_o=0, in.gnt=1.
- Async reset mid-burst: assert rst_ni low between edges. Required: outputs go to reset values immediately without a clock edge; normal operation resumes after release.
